// File: rtl/ibex_offload_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ibex_offload_wb_buffer
// Brief    : Result FIFO and scoreboard that retires offloaded instructions
//            into the register file whenever writeback leaves the port free.
// Revision : 1.0
// ============================================================================
module ibex_offload_wb_buffer #(
  parameter int unsigned Depth          = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_waddr_i,
  output logic        issue_ready_o,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  input  logic [4:0]  res_waddr_i,
  input  logic [31:0] res_wdata_i,
  input  logic        res_we_i,
  input  logic        res_err_i,
  input  logic        rf_we_core_i,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        rf_we_o,
  input  logic [4:0]  rs_a_i,
  input  logic [4:0]  rs_b_i,
  output logic        hazard_o,
  output logic        instr_done_o,
  output logic        err_o,
  output logic [3:0]  outstanding_o
);

  localparam int unsigned      c_ptr_w   = $clog2(Depth);
  localparam logic [c_ptr_w:0] c_depth   = (c_ptr_w + 1)'(Depth);
  localparam logic [3:0]       c_max_out = 4'(MaxOutstanding);

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic        err;
  } entry_t;

  entry_t               r_mem [Depth];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_occ;
  logic [3:0]           r_count;
  logic [31:0]          r_pending;

  entry_t               w_head;
  entry_t               w_new;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;
  logic [31:0]          w_pending_nxt;

  // Ready depends only on registered occupancy so no path exists from the
  // writeback stall back into the coprocessor handshake.
  assign w_empty       = (r_occ == '0);
  assign w_full        = (r_occ == c_depth);
  assign res_ready_o   = ~w_full;
  assign issue_ready_o = (r_count < c_max_out) & ~r_pending[issue_waddr_i];

  assign w_issue = issue_valid_i & issue_ready_o;
  assign w_push  = res_valid_i & res_ready_o;
  assign w_pop   = ~w_empty & ~rf_we_core_i;

  assign w_head = r_mem[r_rd_ptr];
  assign w_new  = '{waddr: res_waddr_i, wdata: res_wdata_i, we: res_we_i, err: res_err_i};

  assign rf_we_o       = w_pop & w_head.we & ~w_head.err & (w_head.waddr != 5'd0);
  assign rf_waddr_o    = w_empty ? 5'd0  : w_head.waddr;
  assign rf_wdata_o    = w_empty ? 32'd0 : w_head.wdata;
  assign instr_done_o  = w_pop;
  assign err_o         = w_pop & w_head.err;
  assign outstanding_o = r_count;

  assign hazard_o = ((rs_a_i != 5'd0) & r_pending[rs_a_i]) |
                    ((rs_b_i != 5'd0) & r_pending[rs_b_i]);

  // Set after clear so a register retired and re-issued in the same cycle
  // stays pending for the new instruction.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) begin
      w_pending_nxt[w_head.waddr] = 1'b0;
    end
    if (w_issue && (issue_waddr_i != 5'd0)) begin
      w_pending_nxt[issue_waddr_i] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_count   <= 4'd0;
      r_pending <= 32'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_occ     <= r_occ + {{c_ptr_w{1'b0}}, w_push} - {{c_ptr_w{1'b0}}, w_pop};
      r_count   <= r_count + {3'b000, w_issue} - {3'b000, w_pop};
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

`ifndef SYNTHESIS
  a_push_needs_outstanding : assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_push |-> (r_count != 4'd0));
  a_pop_yields_to_core : assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_pop |-> !rf_we_core_i);
  a_single_rf_writer : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rf_we_o && rf_we_core_i));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_offload_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_offload_wb_buffer
// Brief    : Scoreboard bench for the offload writeback buffer.
// Revision : 1.0
// ============================================================================
module tb_ibex_offload_wb_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic [4:0]  issue_waddr_i = 5'd0;
  logic        issue_ready_o;
  logic        res_valid_i = 1'b0;
  logic        res_ready_o;
  logic [4:0]  res_waddr_i = 5'd0;
  logic [31:0] res_wdata_i = 32'd0;
  logic        res_we_i = 1'b0;
  logic        res_err_i = 1'b0;
  logic        rf_we_core_i = 1'b0;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_we_o;
  logic [4:0]  rs_a_i = 5'd0;
  logic [4:0]  rs_b_i = 5'd0;
  logic        hazard_o;
  logic        instr_done_o;
  logic        err_o;
  logic [3:0]  outstanding_o;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic mon_we;
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;

  ibex_offload_wb_buffer #(
    .Depth          (2),
    .MaxOutstanding (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .issue_valid_i (issue_valid_i),
    .issue_waddr_i (issue_waddr_i),
    .issue_ready_o (issue_ready_o),
    .res_valid_i   (res_valid_i),
    .res_ready_o   (res_ready_o),
    .res_waddr_i   (res_waddr_i),
    .res_wdata_i   (res_wdata_i),
    .res_we_i      (res_we_i),
    .res_err_i     (res_err_i),
    .rf_we_core_i  (rf_we_core_i),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .rf_we_o       (rf_we_o),
    .rs_a_i        (rs_a_i),
    .rs_b_i        (rs_b_i),
    .hazard_o      (hazard_o),
    .instr_done_o  (instr_done_o),
    .err_o         (err_o),
    .outstanding_o (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Every retirement is matched against the oldest accepted result.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rf_we_o) begin
        checks++;
        if (rf_we_core_i) begin
          errors++;
          $display("FAIL port_conflict: rf_we_o=1 while rf_we_core_i=1");
        end
      end
      if (instr_done_o) begin
        n_done++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: retire with waddr=%0d but no result expected", rf_waddr_o);
        end else begin
          mon_e  = sb_q.pop_front();
          mon_we = mon_e.we & ~mon_e.err & (mon_e.waddr != 5'd0);
          if (rf_we_o !== mon_we || rf_waddr_o !== mon_e.waddr || err_o !== mon_e.err ||
              (mon_we && rf_wdata_o !== mon_e.wdata)) begin
            errors++;
            $display("FAIL retire: got we=%b waddr=%0d wdata=%h err=%b, want we=%b waddr=%0d wdata=%h err=%b",
                     rf_we_o, rf_waddr_o, rf_wdata_o, err_o, mon_we, mon_e.waddr, mon_e.wdata, mon_e.err);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_issue(input logic [4:0] rd, output logic accepted);
    issue_valid_i = 1'b1;
    issue_waddr_i = rd;
    @(negedge clk_i);
    accepted = issue_ready_o;
    tick();
    issue_valid_i = 1'b0;
  endtask

  task automatic do_push(input logic [4:0] rd, input logic [31:0] data,
                         input logic we, input logic err, output logic ok);
    res_valid_i = 1'b1;
    res_waddr_i = rd;
    res_wdata_i = data;
    res_we_i    = we;
    res_err_i   = err;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_i);
      if (res_ready_o) begin
        sb_q.push_back('{waddr: rd, wdata: data, we: we, err: err});
        ok = 1'b1;
      end
      tick();
    end
    res_valid_i = 1'b0;
  endtask

  task automatic wait_drain(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      if (outstanding_o == 4'd0) ok = 1'b1;
    end
    tick();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (issue_ready_o !== 1'b1 || res_ready_o !== 1'b1 || rf_we_o !== 1'b0 ||
        rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0 || hazard_o !== 1'b0 ||
        instr_done_o !== 1'b0 || err_o !== 1'b0 || outstanding_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: ir=%b rr=%b we=%b wa=%0d wd=%h hz=%b dn=%b er=%b out=%0d",
               issue_ready_o, res_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, hazard_o,
               instr_done_o, err_o, outstanding_o);
    end
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic acc, ok;
    int   d0;
    rs_a_i = 5'd5;
    d0 = n_done;
    do_issue(5'd5, acc);
    checks++;
    if (acc !== 1'b1 || outstanding_o !== 4'd1 || hazard_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_issue: acc=%b out=%0d hz=%b, want 1 1 1", acc, outstanding_o, hazard_o);
    end
    do_push(5'd5, 32'hDEADBEEF, 1'b1, 1'b0, ok);
    checks++;
    if (!ok || hazard_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_buffered: push_ok=%b hz=%b, want 1 1", ok, hazard_o);
    end
    @(negedge clk_i);
    checks++;
    if (instr_done_o !== 1'b1 || rf_we_o !== 1'b1 || rf_wdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_write: done=%b we=%b wd=%h, want 1 1 deadbeef", instr_done_o, rf_we_o, rf_wdata_o);
    end
    tick();
    checks++;
    if (outstanding_o !== 4'd0 || hazard_o !== 1'b0 || n_done != d0 + 1) begin
      errors++;
      $display("FAIL basic_retired: out=%0d hz=%b done_pulses=%0d, want 0 0 1", outstanding_o, hazard_o, n_done - d0);
    end
    rs_a_i = 5'd0;
  endtask

  task automatic test_stall();
    logic acc, ok;
    do_issue(5'd6, acc);
    rf_we_core_i = 1'b1;
    do_push(5'd6, 32'h12345678, 1'b1, 1'b0, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (rf_we_o !== 1'b0 || instr_done_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: we=%b done=%b, want 0 0", i, rf_we_o, instr_done_o);
      end
    end
    tick();
    rf_we_core_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd6) begin
      errors++;
      $display("FAIL stall_release: we=%b wa=%0d, want 1 6", rf_we_o, rf_waddr_o);
    end
    tick();
    checks++;
    if (!acc || !ok || outstanding_o !== 4'd0) begin
      errors++;
      $display("FAIL stall_done: acc=%b push=%b out=%0d, want 1 1 0", acc, ok, outstanding_o);
    end
  endtask

  task automatic test_full();
    logic acc, ok;
    int   d0;
    d0 = n_done;
    rf_we_core_i = 1'b1;
    do_issue(5'd1, acc);
    do_issue(5'd2, acc);
    do_issue(5'd3, acc);
    do_push(5'd1, 32'h0000_0011, 1'b1, 1'b0, ok);
    do_push(5'd2, 32'h0000_0022, 1'b1, 1'b0, ok);
    checks++;
    if (res_ready_o !== 1'b0 || outstanding_o !== 4'd3) begin
      errors++;
      $display("FAIL full_ready: rr=%b out=%0d, want 0 3", res_ready_o, outstanding_o);
    end
    res_valid_i = 1'b1;
    res_waddr_i = 5'd3;
    res_wdata_i = 32'h0000_0033;
    res_we_i    = 1'b1;
    res_err_i   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checks++;
      if (res_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL full_hold%0d: rr=%b, want 0", i, res_ready_o);
      end
    end
    tick();
    rf_we_core_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (instr_done_o !== 1'b1 || res_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_cycle: done=%b rr=%b, want 1 0", instr_done_o, res_ready_o);
    end
    tick();
    @(negedge clk_i);
    checks++;
    if (res_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL full_reopen: rr=%b, want 1", res_ready_o);
    end else begin
      sb_q.push_back('{waddr: 5'd3, wdata: 32'h0000_0033, we: 1'b1, err: 1'b0});
    end
    tick();
    res_valid_i = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok || n_done != d0 + 3) begin
      errors++;
      $display("FAIL full_drain: drained=%b retired=%0d, want 1 3", ok, n_done - d0);
    end
  endtask

  task automatic test_err();
    logic acc, ok;
    rs_b_i = 5'd7;
    do_issue(5'd7, acc);
    checks++;
    if (hazard_o !== 1'b1) begin
      errors++;
      $display("FAIL err_hazard: hz=%b, want 1", hazard_o);
    end
    do_push(5'd7, 32'hBAD0BAD0, 1'b1, 1'b1, ok);
    @(negedge clk_i);
    checks++;
    if (instr_done_o !== 1'b1 || err_o !== 1'b1 || rf_we_o !== 1'b0) begin
      errors++;
      $display("FAIL err_retire: done=%b err=%b we=%b, want 1 1 0", instr_done_o, err_o, rf_we_o);
    end
    tick();
    checks++;
    if (hazard_o !== 1'b0 || outstanding_o !== 4'd0) begin
      errors++;
      $display("FAIL err_cleared: hz=%b out=%0d, want 0 0", hazard_o, outstanding_o);
    end
    rs_b_i = 5'd0;
  endtask

  task automatic test_limits();
    logic acc, ok;
    do_issue(5'd10, acc);
    do_issue(5'd11, acc);
    do_issue(5'd12, acc);
    do_issue(5'd10, acc);
    checks++;
    if (acc !== 1'b0 || outstanding_o !== 4'd3) begin
      errors++;
      $display("FAIL limit_pending: acc=%b out=%0d, want 0 3", acc, outstanding_o);
    end
    do_issue(5'd13, acc);
    do_issue(5'd14, acc);
    checks++;
    if (acc !== 1'b0 || outstanding_o !== 4'd4) begin
      errors++;
      $display("FAIL limit_max: acc=%b out=%0d, want 0 4", acc, outstanding_o);
    end
    do_push(5'd10, 32'hA0, 1'b1, 1'b0, ok);
    do_push(5'd11, 32'hA1, 1'b1, 1'b0, ok);
    issue_valid_i = 1'b1;
    issue_waddr_i = 5'd14;
    @(negedge clk_i);
    checks++;
    if (issue_ready_o !== 1'b1 || instr_done_o !== 1'b1) begin
      errors++;
      $display("FAIL limit_concurrent: ir=%b done=%b, want 1 1", issue_ready_o, instr_done_o);
    end
    tick();
    issue_valid_i = 1'b0;
    checks++;
    if (outstanding_o !== 4'd3) begin
      errors++;
      $display("FAIL limit_count: out=%0d, want 3", outstanding_o);
    end
    do_push(5'd12, 32'hA2, 1'b1, 1'b0, ok);
    do_push(5'd13, 32'hA3, 1'b1, 1'b0, ok);
    do_push(5'd14, 32'hA4, 1'b1, 1'b0, ok);
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL limit_drain: out=%0d, want 0", outstanding_o);
    end
  endtask

  task automatic test_reset_mid();
    logic acc, ok;
    rf_we_core_i = 1'b1;
    rs_a_i = 5'd20;
    do_issue(5'd20, acc);
    do_issue(5'd21, acc);
    do_push(5'd20, 32'hC0, 1'b1, 1'b0, ok);
    do_push(5'd21, 32'hC1, 1'b1, 1'b0, ok);
    rst_ni = 1'b0;
    sb_q.delete();
    #1;
    checks++;
    if (issue_ready_o !== 1'b1 || res_ready_o !== 1'b1 || rf_we_o !== 1'b0 ||
        rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0 || hazard_o !== 1'b0 ||
        instr_done_o !== 1'b0 || err_o !== 1'b0 || outstanding_o !== 4'd0) begin
      errors++;
      $display("FAIL midreset_outputs: ir=%b rr=%b we=%b wa=%0d wd=%h hz=%b dn=%b er=%b out=%0d",
               issue_ready_o, res_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, hazard_o,
               instr_done_o, err_o, outstanding_o);
    end
    tick();
    rst_ni = 1'b1;
    rf_we_core_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (rf_we_o !== 1'b0 || instr_done_o !== 1'b0) begin
        errors++;
        $display("FAIL midreset_flushed%0d: we=%b done=%b, want 0 0", i, rf_we_o, instr_done_o);
      end
    end
    rs_a_i = 5'd0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_err();
    test_limits();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d results never retired, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
